// File: rtl/alarm_clock_pkg.sv
// Shared types, widths and helpers for the multi-alarm clock core.
package alarm_clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN       = 2'd0,
    MODE_SET_TIME  = 2'd1,
    MODE_SET_ALARM = 2'd2
  } mode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RING   = 2'd1,
    SNOOZE = 2'd2
  } state_e;

  localparam int unsigned HR_W  = 5;
  localparam int unsigned MIN_W = 6;
  localparam int unsigned SEC_W = 6;
  localparam int unsigned CNT_W = 12;

  // dir=1 steps up, dir=0 steps down; wraps between 0 and max.
  function automatic logic [5:0] inc_wrap(input logic [5:0] value,
                                          input logic [5:0] max,
                                          input logic       dir);
    if (dir) return (value == max) ? 6'd0 : value + 6'd1;
    else     return (value == 6'd0) ? max : value - 6'd1;
  endfunction

endpackage

// File: rtl/bin2bcd_2d.sv
// Combinational 0..63 binary to two BCD digits {tens, units}.
module bin2bcd_2d (
  input  logic [5:0] bin,
  output logic [7:0] bcd
);

  logic [5:0] rem;
  logic [3:0] tens;

  always_comb begin
    rem  = bin;
    tens = '0;
    for (int unsigned i = 0; i < 6; i++) begin
      if (rem >= 6'd10) begin
        rem  = rem - 6'd10;
        tens = tens + 4'd1;
      end
    end
    bcd = {tens, 4'(rem)};
  end

endmodule

// File: rtl/multi_alarm_clock.sv
// 24-hour clock with NUM_ALARMS alarms, adjust modes and ring/snooze/auto-stop FSM.
module multi_alarm_clock
  import alarm_clock_pkg::*;
#(
  parameter int unsigned NUM_ALARMS = 2,
  parameter int unsigned SNOOZE_MIN = 5,
  parameter int unsigned RING_MIN   = 1,
  localparam int unsigned SEL_W     = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic [1:0]            mode,
  input  logic [SEL_W-1:0]      sel_alarm,
  input  logic                  field,
  input  logic                  up,
  input  logic                  down,
  input  logic [NUM_ALARMS-1:0] alarm_en,
  input  logic                  snooze,
  input  logic                  stop,
  output logic [HR_W-1:0]       hours,
  output logic [MIN_W-1:0]      minutes,
  output logic [SEC_W-1:0]      seconds,
  output logic [15:0]           disp_bcd,
  output logic                  ringing,
  output logic [SEL_W-1:0]      ring_id
);

  localparam logic [CNT_W-1:0] SNOOZE_LOAD = CNT_W'(SNOOZE_MIN * 60);
  localparam logic [CNT_W-1:0] RING_LOAD   = CNT_W'(RING_MIN * 60);

  logic [HR_W-1:0]  hours_q, hours_d;
  logic [MIN_W-1:0] minutes_q, minutes_d;
  logic [SEC_W-1:0] seconds_q, seconds_d;
  logic [HR_W-1:0]  alm_hr_q  [NUM_ALARMS];
  logic [HR_W-1:0]  alm_hr_d  [NUM_ALARMS];
  logic [MIN_W-1:0] alm_min_q [NUM_ALARMS];
  logic [MIN_W-1:0] alm_min_d [NUM_ALARMS];

  state_e           state_q, state_d;
  logic [SEL_W-1:0] ring_id_q, ring_id_d;
  logic [CNT_W-1:0] ring_cnt_q, ring_cnt_d;
  logic [CNT_W-1:0] snz_cnt_q, snz_cnt_d;
  logic             ringing_q;
  logic [15:0]      disp_q, disp_d;

  mode_e            mode_eff;
  logic             adj, sel_ok, rollover, hit, trigger;
  logic [SEL_W-1:0] hit_idx;
  logic [HR_W-1:0]  disp_hr;
  logic [MIN_W-1:0] disp_min;
  logic [7:0]       hr_bcd, min_bcd;

  assign mode_eff = (mode == 2'd3) ? MODE_RUN : mode_e'(mode);
  assign adj      = up ^ down;
  assign sel_ok   = 32'(sel_alarm) < NUM_ALARMS;

  // Time and alarm register updates.
  always_comb begin
    hours_d   = hours_q;
    minutes_d = minutes_q;
    seconds_d = seconds_q;
    alm_hr_d  = alm_hr_q;
    alm_min_d = alm_min_q;
    rollover  = 1'b0;
    if (mode_eff == MODE_SET_TIME) begin
      seconds_d = '0;
      if (adj) begin
        if (field) hours_d   = HR_W'(inc_wrap({1'b0, hours_q}, 6'd23, up));
        else       minutes_d = inc_wrap(minutes_q, 6'd59, up);
      end
    end else begin
      if (tick) begin
        if (seconds_q == 6'd59) begin
          seconds_d = '0;
          rollover  = 1'b1;
          minutes_d = inc_wrap(minutes_q, 6'd59, 1'b1);
          if (minutes_q == 6'd59)
            hours_d = HR_W'(inc_wrap({1'b0, hours_q}, 6'd23, 1'b1));
        end else begin
          seconds_d = seconds_q + 6'd1;
        end
      end
      if (mode_eff == MODE_SET_ALARM && adj && sel_ok) begin
        if (field) alm_hr_d[sel_alarm] = HR_W'(inc_wrap({1'b0, alm_hr_q[sel_alarm]}, 6'd23, up));
        else       alm_min_d[sel_alarm] = inc_wrap(alm_min_q[sel_alarm], 6'd59, up);
      end
    end
  end

  // Lowest enabled alarm matching the new HH:MM wins.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
      if (!hit && alarm_en[i] && alm_hr_q[i] == hours_d && alm_min_q[i] == minutes_d) begin
        hit     = 1'b1;
        hit_idx = SEL_W'(i);
      end
    end
  end

  assign trigger = hit && tick && rollover && (mode_eff == MODE_RUN);

  always_comb begin
    state_d    = state_q;
    ring_id_d  = ring_id_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;
    if (mode_eff != MODE_RUN) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (trigger) begin
            state_d    = RING;
            ring_id_d  = hit_idx;
            ring_cnt_d = '0;
          end
        end
        RING: begin
          if (!alarm_en[ring_id_q] || stop) begin
            state_d = IDLE;
          end else if (snooze) begin
            state_d   = SNOOZE;
            snz_cnt_d = SNOOZE_LOAD;
          end else if (tick) begin
            ring_cnt_d = ring_cnt_q + 1'b1;
            if (ring_cnt_d == RING_LOAD) state_d = IDLE;
          end
        end
        SNOOZE: begin
          if (!alarm_en[ring_id_q] || stop) begin
            state_d = IDLE;
          end else if (tick) begin
            snz_cnt_d = snz_cnt_q - 1'b1;
            if (snz_cnt_d == '0) begin
              state_d    = RING;
              ring_cnt_d = '0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    disp_hr  = hours_q;
    disp_min = minutes_q;
    if (mode_eff == MODE_SET_ALARM) begin
      disp_hr  = sel_ok ? alm_hr_q[sel_alarm]  : '0;
      disp_min = sel_ok ? alm_min_q[sel_alarm] : '0;
    end
    disp_d = {hr_bcd, min_bcd};
  end

  bin2bcd_2d u_hr_bcd  (.bin({1'b0, disp_hr}), .bcd(hr_bcd));
  bin2bcd_2d u_min_bcd (.bin(disp_min),        .bcd(min_bcd));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hours_q    <= '0;
      minutes_q  <= '0;
      seconds_q  <= '0;
      for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
        alm_hr_q[i]  <= '0;
        alm_min_q[i] <= '0;
      end
      state_q    <= IDLE;
      ring_id_q  <= '0;
      ring_cnt_q <= '0;
      snz_cnt_q  <= '0;
      ringing_q  <= 1'b0;
      disp_q     <= '0;
    end else begin
      hours_q    <= hours_d;
      minutes_q  <= minutes_d;
      seconds_q  <= seconds_d;
      alm_hr_q   <= alm_hr_d;
      alm_min_q  <= alm_min_d;
      state_q    <= state_d;
      ring_id_q  <= ring_id_d;
      ring_cnt_q <= ring_cnt_d;
      snz_cnt_q  <= snz_cnt_d;
      ringing_q  <= (state_d == RING);
      disp_q     <= disp_d;
    end
  end

  assign hours    = hours_q;
  assign minutes  = minutes_q;
  assign seconds  = seconds_q;
  assign disp_bcd = disp_q;
  assign ringing  = ringing_q;
  assign ring_id  = ring_id_q;

endmodule

// File: doc/multi_alarm_clock.md
# multi_alarm_clock

Parametrised successor to the single-alarm clock core. Keeps 24-hour HH:MM:SS time and holds NUM_ALARMS independently enabled alarms. Provides adjust modes for time and alarms, and a ring/snooze/auto-stop state machine. Sits between the board's clock dividers and push detectors, which supply the tick and one-cycle buttons, and the seven-segment multiplexer, which consumes disp_bcd.

## Interface

Parameters:
- NUM_ALARMS, 2: number of alarm registers (1..8)
- SNOOZE_MIN, 5: snooze length in minutes (1..59)
- RING_MIN, 1: ring time without user action before auto-stop (1..59)

Ports:
- clk  in  1  system clock; one clock domain
- rst  in  1  asynchronous, active-low reset
- tick  in  1  one-cycle 1 Hz enable from the divider
- mode  in  2  0 = run, 1 = set time, 2 = set alarm, 3 = treated as 0
- sel_alarm  in  max(1,$clog2(NUM_ALARMS))  alarm being adjusted or displayed in mode 2
- field  in  1  0 = minutes, 1 = hours
- up, down  in  1  one-cycle adjust pulses
- alarm_en  in  NUM_ALARMS  per-alarm enable, level
- snooze, stop  in  1  one-cycle pulses
- hours  out  5  current hour 0..23
- minutes, seconds  out  6  0..59
- disp_bcd  out  16  {H tens, H units, M tens, M units} BCD; shows alarm[sel_alarm] in mode 2, else time
- ringing  out  1  alarm sounding
- ring_id  out  max(1,$clog2(NUM_ALARMS))  index of the alarm that fired

## Operation

- Reset values:
  - time is 00:00:00
  - every alarm is 00:00
  - FSM is IDLE; ringing=0, ring_id=0, disp_bcd=16'h0000
  - snooze and ring counters are 0
- Run (mode 0, 3):
  - on tick, seconds increments with carry into minutes and hours
  - 23:59:59 wraps to 00:00:00
  - up and down are ignored
- Set time (mode 1):
  - seconds are held at 0 and tick is ignored
  - up/down changes the selected field by ±1 and wraps (minutes 59↔0, hours 23↔0) with no carry
  - up and down in the same cycle: no change
- Set alarm (mode 2):
  - up/down acts on alarm[sel_alarm]; same wrap rules as mode 1
  - time keeps running
  - sel_alarm ≥ NUM_ALARMS: adjust is ignored, disp_bcd shows 00:00
- Trigger:
  - fires on a tick in mode 0/3 that moves seconds to 0, when the new HH:MM equals alarm i and alarm_en[i]=1
  - simultaneous matches: the lowest index wins
  - evaluated only in IDLE; ignored in RING and SNOOZE
- FSM:
  - IDLE → RING on trigger; ring_id latched, ring counter cleared
  - RING:
    - ringing=1
    - stop → IDLE
    - snooze → SNOOZE; counter loaded with SNOOZE_MIN*60
    - RING_MIN*60 ticks with no action → IDLE
  - SNOOZE:
    - ringing=0; counter decrements on tick
    - reaching 0 → RING; ring counter cleared
    - stop → IDLE
  - stop and snooze in the same cycle: stop wins
  - mode 1 or 2 from any state → IDLE
  - clearing alarm_en[ring_id] while in RING or SNOOZE → IDLE
- Counters are sized for 59*60 (12 bits); loads are computed at elaboration time.

## Timing

- All outputs are registered. Time outputs change one clock after the tick or up/down cycle.
- ringing rises one clock after the triggering tick and falls one clock after stop, snooze or auto-stop.
- disp_bcd is registered from the same-cycle state and lags time by one clock.
- Reset is asynchronous: asserting it mid-ring clears everything immediately. Release is synchronous to clk.
- tick and up/down in the same cycle in mode 2: both take effect.

## Structure

- Package alarm_clock_pkg:
  - mode encodings MODE_RUN, MODE_SET_TIME, MODE_SET_ALARM
  - FSM state enum IDLE/RING/SNOOZE
  - widths for hours, minutes and seconds
  - the wrap function inc_wrap(value, max, dir)
- Sub-module bin2bcd_2d: 0..59 binary to two BCD digits, combinational; instantiated twice for disp_bcd.
- Alarm registers are an unpacked array indexed by sel_alarm. The matcher is a priority loop over NUM_ALARMS.

## Test plan

- Reset, then 3661 ticks in mode 0 → hours=1, minutes=1, seconds=1, disp_bcd=16'h0101. From 23:59:59, one more tick → 00:00:00.
- Mode 1, field=0 at minutes=0, one down pulse → minutes=59, hours unchanged. up and down together → no change.
- Alarm 0 = 07:00 and alarm 1 = 07:00, both enabled, time 06:59:59, one tick → ringing=1 and ring_id=0 on the next clock.
- While ringing, snooze pulse → ringing=0. After exactly 300 ticks (SNOOZE_MIN=5) → ringing=1. Then stop → ringing=0 and the state returns to IDLE.
- Ringing with no action for 60 ticks → ringing=0. No retrigger until the next matching minute boundary.
- Assert rst low mid-snooze → all outputs at reset values in the same cycle, with no clock needed. Trigger with alarm_en=0 → no ring.
